// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, condition evaluation, redirect selection and
// an instruction latch that hides the one-cycle synchronous memory latency.
module fetch_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetchPhase,
    input  logic             pcAdd,
    input  logic             pcBranch,
    input  logic             pcJump,
    input  logic [3:0]       flagOp,
    input  logic [4:0]       flags,
    input  logic [WIDTH-1:0] immediate,
    input  logic [WIDTH-1:0] jumpTarget,
    input  logic [WIDTH-1:0] memData,
    output logic [WIDTH-1:0] memAddr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pcPlusOne,
    output logic [WIDTH-1:0] instruction,
    output logic             taken,
    output logic             protoErr,
    output logic [15:0]      redirectCount
);

    logic             flagC, flagL, flagF, flagZ, flagN;
    logic             condTrue;
    logic             anyPulse;
    logic             badPattern;
    logic             redirectTaken;
    logic             pending;
    logic [WIDTH-1:0] pcNext;
    logic [WIDTH-1:0] pcRel;
    logic [WIDTH-1:0] instrReg;

    assign {flagC, flagL, flagF, flagZ, flagN} = flags;

    always_comb begin
        condTrue = 1'b1;
        case (flagOp)
            4'h0:    condTrue = flagZ;
            4'h1:    condTrue = ~flagZ;
            4'h2:    condTrue = flagC;
            4'h3:    condTrue = ~flagC;
            4'h4:    condTrue = flagL;
            4'h5:    condTrue = ~flagL;
            4'h6:    condTrue = flagN;
            4'h7:    condTrue = ~flagN;
            4'h8:    condTrue = flagF;
            4'h9:    condTrue = ~flagF;
            4'hA:    condTrue = ~flagL & ~flagZ;
            4'hB:    condTrue = flagL | flagZ;
            4'hC:    condTrue = ~flagN & ~flagZ;
            4'hD:    condTrue = flagN | flagZ;
            default: condTrue = 1'b1;
        endcase
    end

    assign pcPlusOne     = pc + WIDTH'(1);
    assign pcRel         = pc + immediate;
    assign anyPulse      = pcAdd | pcBranch | pcJump;
    assign badPattern    = (pcAdd & pcBranch) | (pcAdd & pcJump) | (pcBranch & pcJump)
                         | (fetchPhase & anyPulse);
    assign redirectTaken = (pcJump | pcBranch) & condTrue;

    always_comb begin
        pcNext = pc;
        if (pcJump)
            pcNext = condTrue ? jumpTarget : pcPlusOne;
        else if (pcBranch)
            pcNext = condTrue ? pcRel : pcPlusOne;
        else if (pcAdd)
            pcNext = pcPlusOne;
    end

    // Addressing memory with pcNext lets memData hold mem[pc] right after an update.
    assign memAddr = reset ? pcNext : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc            <= '0;
            instrReg      <= '0;
            taken         <= 1'b0;
            protoErr      <= 1'b0;
            redirectCount <= '0;
            pending       <= 1'b1;
        end else begin
            pc      <= pcNext;
            pending <= anyPulse | (pcNext != pc);
            if (pending)
                instrReg <= memData;
            if (pcJump | pcBranch)
                taken <= condTrue;
            if (redirectTaken)
                redirectCount <= redirectCount + 16'd1;
            if (badPattern)
                protoErr <= 1'b1;
        end
    end

    // Fresh memory data is forwarded while the latch is still catching up.
    assign instruction = pending ? memData : instrReg;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural PC model feeding a scoreboard
// queue, plus a synchronous instruction memory model.
module tb_fetch_unit;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          fetchPhase = 1'b0;
    logic          pcAdd = 1'b0;
    logic          pcBranch = 1'b0;
    logic          pcJump = 1'b0;
    logic [3:0]    flagOp = '0;
    logic [4:0]    flags = '0;
    logic [W-1:0]  immediate = '0;
    logic [W-1:0]  jumpTarget = '0;
    logic [W-1:0]  memData = '0;
    logic [W-1:0]  scramble = '0;
    logic [W-1:0]  memAddr, pc, pcPlusOne, instruction;
    logic          taken, protoErr;
    logic [15:0]   redirectCount;

    fetch_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .fetchPhase(fetchPhase), .pcAdd(pcAdd),
        .pcBranch(pcBranch), .pcJump(pcJump), .flagOp(flagOp), .flags(flags),
        .immediate(immediate), .jumpTarget(jumpTarget), .memData(memData),
        .memAddr(memAddr), .pc(pc), .pcPlusOne(pcPlusOne), .instruction(instruction),
        .taken(taken), .protoErr(protoErr), .redirectCount(redirectCount)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memval(input logic [15:0] a);
        if (a == 16'h0000) return 16'h5301;
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    always @(posedge clk) memData <= memval(memAddr) ^ scramble;

    typedef struct {
        logic [15:0] pc;
        logic        tk;
        logic [15:0] cnt;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] m_pc = '0;
    logic [15:0] m_cnt = '0;
    logic        m_taken = 1'b0;
    logic        m_err = 1'b0;

    function automatic logic cond_ok(input logic [3:0] op, input logic [4:0] f);
        logic c, l, fl, z, n;
        {c, l, fl, z, n} = f;
        case (op)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return l;
            4'd5:  return !l;
            4'd6:  return n;
            4'd7:  return !n;
            4'd8:  return fl;
            4'd9:  return !fl;
            4'd10: return !l && !z;
            4'd11: return l || z;
            4'd12: return !n && !z;
            4'd13: return n || z;
            default: return 1'b1;
        endcase
    endfunction

    // One update pulse across one rising edge; expectation queued when driven.
    task automatic pulse(input logic add, input logic br, input logic jmp, input logic [3:0] op,
                         input logic [4:0] flg, input logic [15:0] imm, input logic [15:0] tgt,
                         input logic fp);
        exp_t e;
        logic c;
        @(negedge clk);
        pcAdd = add; pcBranch = br; pcJump = jmp; flagOp = op; flags = flg;
        immediate = imm; jumpTarget = tgt; fetchPhase = fp;
        c = cond_ok(op, flg);
        if ((add && br) || (add && jmp) || (br && jmp) || (fp && (add || br || jmp))) m_err = 1'b1;
        if (jmp) begin
            m_taken = c;
            m_pc = c ? tgt : m_pc + 16'd1;
            if (c) m_cnt = m_cnt + 16'd1;
        end else if (br) begin
            m_taken = c;
            m_pc = c ? m_pc + imm : m_pc + 16'd1;
            if (c) m_cnt = m_cnt + 16'd1;
        end else if (add) begin
            m_pc = m_pc + 16'd1;
        end
        e.pc = m_pc; e.tk = m_taken; e.cnt = m_cnt; e.err = m_err;
        sb.push_back(e);
        @(posedge clk); #1;
        pcAdd = 1'b0; pcBranch = 1'b0; pcJump = 1'b0; fetchPhase = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (pc !== 16'h0 || memAddr !== 16'h0 || taken !== 1'b0 || protoErr !== 1'b0 || redirectCount !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state: pc=%h memAddr=%h taken=%b protoErr=%b cnt=%h, required all zero",
                     pc, memAddr, taken, protoErr, redirectCount);
        end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1; fetchPhase = 1'b1;
        n_checks++;
        if (instruction !== 16'h5301 || pc !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_first_fetch: instruction=%h pc=%h, required 5301 0000", instruction, pc);
        end
    endtask

    task automatic test_branch;
        exp_t e;
        pulse(0, 0, 1, 4'hE, 5'b0, 16'h0, 16'h0010, 0);
        e = sb.pop_front();
        pulse(0, 1, 0, 4'h0, 5'b00010, 16'hFFFC, 16'h0, 0);
        e = sb.pop_front();
        n_checks++;
        if (pc !== 16'h000C || pc !== e.pc || taken !== 1'b1 || redirectCount !== e.cnt) begin
            n_fail++;
            $display("FAIL branch_taken: pc=%h taken=%b cnt=%h, required 000c 1 %h", pc, taken, redirectCount, e.cnt);
        end
        n_checks++;
        if (instruction !== memval(16'h000C)) begin
            n_fail++;
            $display("FAIL branch_fetch: instruction=%h, required %h", instruction, memval(16'h000C));
        end
        pulse(0, 0, 1, 4'hE, 5'b0, 16'h0, 16'h0010, 0);
        e = sb.pop_front();
        pulse(0, 1, 0, 4'h0, 5'b00000, 16'hFFFC, 16'h0, 0);
        e = sb.pop_front();
        n_checks++;
        if (pc !== 16'h0011 || taken !== 1'b0 || redirectCount !== e.cnt) begin
            n_fail++;
            $display("FAIL branch_not_taken: pc=%h taken=%b cnt=%h, required 0011 0 %h", pc, taken, redirectCount, e.cnt);
        end
    endtask

    task automatic test_jal;
        exp_t e;
        pulse(0, 0, 1, 4'hE, 5'b0, 16'h0, 16'h0020, 0);
        e = sb.pop_front();
        pulse(0, 0, 1, 4'hF, 5'b0, 16'h0, 16'h0400, 0);
        e = sb.pop_front();
        n_checks++;
        if (pc !== 16'h0400 || pcPlusOne !== 16'h0401 || instruction !== memval(16'h0400) || taken !== e.tk) begin
            n_fail++;
            $display("FAIL jal: pc=%h pcPlusOne=%h instr=%h taken=%b, required 0400 0401 %h %b",
                     pc, pcPlusOne, instruction, taken, memval(16'h0400), e.tk);
        end
    endtask

    task automatic test_wrap;
        exp_t e;
        pulse(0, 0, 1, 4'hE, 5'b0, 16'h0, 16'hFFFF, 0);
        e = sb.pop_front();
        @(negedge clk);
        pcAdd = 1'b1; fetchPhase = 1'b0;
        #1;
        n_checks++;
        if (memAddr !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_memaddr: memAddr=%h, required 0000", memAddr);
        end
        @(posedge clk); #1;
        pcAdd = 1'b0; fetchPhase = 1'b1; m_pc = 16'h0000;
        n_checks++;
        if (pc !== 16'h0000 || instruction !== 16'h5301) begin
            n_fail++;
            $display("FAIL wrap_pc: pc=%h instr=%h, required 0000 5301", pc, instruction);
        end
        pulse(0, 0, 1, 4'hE, 5'b0, 16'h0, 16'h0002, 0);
        e = sb.pop_front();
        pulse(0, 1, 0, 4'hE, 5'b0, 16'hFFFD, 16'h0, 0);
        e = sb.pop_front();
        n_checks++;
        if (pc !== 16'hFFFF || instruction !== memval(16'hFFFF)) begin
            n_fail++;
            $display("FAIL wrap_branch: pc=%h instr=%h, required ffff %h", pc, instruction, memval(16'hFFFF));
        end
    endtask

    task automatic test_conditions;
        exp_t        e;
        logic [4:0]  f;
        logic [15:0] imm, tgt;
        for (int op = 0; op < 16; op++) begin
            for (int k = 0; k < 3; k++) begin
                f   = (k == 0) ? 5'b00000 : (k == 1) ? 5'b11111 : 5'($urandom_range(31));
                imm = 16'($urandom_range(65535));
                tgt = 16'($urandom_range(65535));
                if (k == 1) pulse(0, 1, 0, 4'(op), f, imm, tgt, 0);
                else        pulse(0, 0, 1, 4'(op), f, imm, tgt, 0);
                e = sb.pop_front();
                n_checks++;
                if (pc !== e.pc || taken !== e.tk || redirectCount !== e.cnt || instruction !== memval(e.pc)) begin
                    n_fail++;
                    $display("FAIL cond op=%0d flags=%b: pc=%h taken=%b cnt=%h instr=%h, required %h %b %h %h",
                             op, f, pc, taken, redirectCount, instruction, e.pc, e.tk, e.cnt, memval(e.pc));
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        pulse(0, 0, 1, 4'hE, 5'b0, 16'h0, 16'h1230, 0);
        e = sb.pop_front();
        for (int i = 0; i < 6; i++) begin
            if (i == 3) pulse(0, 1, 0, 4'hE, 5'b0, 16'h0100, 16'h0, 0);
            else        pulse(1, 0, 0, 4'h0, 5'b0, 16'h0, 16'h0, 0);
            e = sb.pop_front();
            n_checks++;
            if (pc !== e.pc || instruction !== memval(e.pc) || protoErr !== e.err) begin
                n_fail++;
                $display("FAIL back_to_back step %0d: pc=%h instr=%h err=%b, required %h %h %b",
                         i, pc, instruction, protoErr, e.pc, memval(e.pc), e.err);
            end
        end
    endtask

    task automatic test_hold;
        exp_t e;
        pulse(1, 0, 0, 4'h0, 5'b0, 16'h0, 16'h0, 0);
        e = sb.pop_front();
        @(posedge clk); #1;
        scramble = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (instruction !== memval(e.pc) || pc !== e.pc) begin
                n_fail++;
                $display("FAIL hold_latched %0d: instr=%h pc=%h, required %h %h", i, instruction, pc, memval(e.pc), e.pc);
            end
        end
        scramble = 16'h0000;
        @(posedge clk); #1;
    endtask

    task automatic test_proto;
        exp_t e;
        pulse(1, 0, 1, 4'hE, 5'b0, 16'h0, 16'h0777, 0);
        e = sb.pop_front();
        n_checks++;
        if (pc !== 16'h0777 || protoErr !== 1'b1 || e.err !== 1'b1) begin
            n_fail++;
            $display("FAIL proto_set: pc=%h protoErr=%b, required 0777 1", pc, protoErr);
        end
        pulse(1, 0, 0, 4'h0, 5'b0, 16'h0, 16'h0, 0);
        e = sb.pop_front();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (protoErr !== 1'b1 || pc !== e.pc) begin
            n_fail++;
            $display("FAIL proto_sticky: protoErr=%b pc=%h, required 1 %h", protoErr, pc, e.pc);
        end
    endtask

    task automatic test_reset_redirect;
        @(negedge clk);
        pcJump = 1'b1; flagOp = 4'hE; jumpTarget = 16'h1234; fetchPhase = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (pc !== 16'h0 || memAddr !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_async: pc=%h memAddr=%h, required 0000 0000", pc, memAddr);
        end
        @(posedge clk); #1;
        n_checks++;
        if (pc !== 16'h0 || taken !== 1'b0 || redirectCount !== 16'h0 || protoErr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_redirect: pc=%h taken=%b cnt=%h err=%b, required 0000 0 0000 0",
                     pc, taken, redirectCount, protoErr);
        end
        pcJump = 1'b0; fetchPhase = 1'b0;
        m_pc = '0; m_cnt = '0; m_taken = 1'b0; m_err = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1; fetchPhase = 1'b1;
        n_checks++;
        if (instruction !== 16'h5301 || pc !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_refetch: instr=%h pc=%h, required 5301 0000", instruction, pc);
        end
    endtask

    task automatic test_proto_fetch;
        exp_t e;
        pulse(1, 0, 0, 4'h0, 5'b0, 16'h0, 16'h0, 1);
        e = sb.pop_front();
        n_checks++;
        if (protoErr !== 1'b1 || pc !== 16'h0001 || pc !== e.pc) begin
            n_fail++;
            $display("FAIL proto_fetch: protoErr=%b pc=%h, required 1 0001", protoErr, pc);
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jal();
        test_wrap();
        test_conditions();
        test_back_to_back();
        test_hold();
        test_proto();
        test_reset_redirect();
        test_proto_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, which sets the PC, address and instruction width.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port fetchPhase, input, 1 bit: controller is in its FETCH cycle and is sampling instruction.
REQ-005 Port pcAdd, input, 1 bit: one-cycle pulse requesting pc <= pc+1.
REQ-006 Port pcBranch, input, 1 bit: one-cycle pulse requesting a conditional PC-relative branch.
REQ-007 Port pcJump, input, 1 bit: one-cycle pulse requesting a conditional absolute jump.
REQ-008 Port flagOp, input, 4 bits: condition code for the branch or jump.
REQ-009 Port flags, input, 5 bits: {C,L,F,Z,N} from the flag register.
REQ-010 Port immediate, input, WIDTH bits: branch displacement, already sign-extended.
REQ-011 Port jumpTarget, input, WIDTH bits: register-A value used as the jump target.
REQ-012 Port memData, input, WIDTH bits: synchronous instruction memory read data, returned one cycle after memAddr is presented.
REQ-013 Port memAddr, output, WIDTH bits: instruction memory address.
REQ-014 Port pc, output, WIDTH bits: current PC register.
REQ-015 Port pcPlusOne, output, WIDTH bits: pc+1, the link value used by JAL.
REQ-016 Port instruction, output, WIDTH bits: instruction at pc, presented to the controller.
REQ-017 Port taken, output, 1 bit: registered; 1 when the last branch or jump was taken.
REQ-018 Port protoErr, output, 1 bit: sticky; set on an illegal request pattern.
REQ-019 Port redirectCount, output, 16 bits: count of taken branches and jumps.

Function
REQ-020 Condition evaluation SHALL be combinational and decode flagOp as follows:
- 0000 EQ: Z=1
- 0001 NE: Z=0
- 0010 CS: C=1
- 0011 CC: C=0
- 0100 HI: L=1
- 0101 LS: L=0
- 0110 GT: N=1
- 0111 LE: N=0
- 1000 FS: F=1
- 1001 FC: F=0
- 1010 LO: L=0 and Z=0
- 1011 HS: L=1 or Z=1
- 1100 LT: N=0 and Z=0
- 1101 GE: N=1 or Z=1
- 1110 UC: always
- 1111 UC: always (the JAL path)
REQ-021 The next PC (pcNext) SHALL be selected with priority pcJump > pcBranch > pcAdd:
- pcJump with condition true: jumpTarget
- pcBranch with condition true: pc+immediate, modulo 2^WIDTH
- pcJump or pcBranch with condition false: pc+1
- pcAdd: pc+1
- no pulse: pc
REQ-022 pc SHALL load pcNext on each rising clock edge.
REQ-023 pc+1 and pc+immediate SHALL wrap modulo 2^WIDTH, so 0xFFFF+1 gives 0x0000 and 0x0002+0xFFFD gives 0xFFFF.
REQ-024 memAddr SHALL equal pcNext combinationally, so that memData in the cycle after an update holds mem[pc].
REQ-025 A pending bit SHALL be set on any cycle in which pc changes value or any update pulse is asserted, and cleared in the following cycle.
REQ-026 While pending=1, instruction SHALL equal memData and instrReg SHALL capture memData; while pending=0, instruction SHALL equal instrReg.
REQ-027 When fetchPhase=1 in the cycle directly after an update pulse, instruction SHALL be mem[new pc] with zero added wait cycles.
REQ-028 taken SHALL be registered: it updates only on pcJump or pcBranch cycles (1 if the condition is true, else 0) and holds otherwise.
REQ-029 redirectCount SHALL increment by 1 on each taken redirect and wrap from 0xFFFF to 0x0000.
REQ-030 protoErr SHALL set and remain set until reset if two or more of pcAdd, pcBranch and pcJump are asserted together, or if any of them is asserted while fetchPhase=1.
REQ-031 The PC update SHALL still follow REQ-021 priority when protoErr conditions occur.
REQ-032 pcPlusOne SHALL be combinational: pc+1 with wrap.

Reset
REQ-033 While reset=0, the following SHALL hold: pc=0, memAddr=0, instrReg=0, taken=0, protoErr=0, redirectCount=0, pending=1.
REQ-034 On the first edge after reset is deasserted, instrReg SHALL capture mem[0].
REQ-035 Reset asserted mid-operation, including in the cycle of a redirect, SHALL override immediately and discard the redirect.

Verification
REQ-036 Reset deasserted with mem[0]=0x5301 and fetchPhase=1 in the next cycle -> instruction=0x5301, pc=0.
REQ-037 pc=0x0010, pcBranch=1, flagOp=0000, Z=1, immediate=0xFFFC -> pc=0x000C, taken=1, redirectCount=1; same stimulus with Z=0 -> pc=0x0011, taken=0.
REQ-038 pc=0x0020, pcJump=1, flagOp=1111, jumpTarget=0x0400 -> pc=0x0400, pcPlusOne=0x0401, instruction=mem[0x0400] in the next cycle.
REQ-039 pc=0xFFFF with pcAdd=1 -> pc=0x0000 and memAddr=0x0000 in the same cycle.
REQ-040 pcAdd=1 and pcJump=1 with flagOp=1110 -> pc=jumpTarget, protoErr=1, and protoErr remains 1 until reset.
REQ-041 Reset asserted in the same cycle as a taken pcJump -> pc=0, taken=0, redirectCount=0.
